// File: rtl/apbspi_pkg.sv
// Shared types and defaults for the apbspi SPI slave endpoint.
package apbspi_pkg;

    // Slave frame sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } apbspi_slave_state_t;

    // Default word size; must match the apbspi master
    localparam int APBSPI_WORD_WIDTH  = 32;
    // Default synchroniser depth on the asynchronous SPI pins
    localparam int APBSPI_SYNC_STAGES = 2;

endpackage

// File: rtl/apbspi_sync_edge.sv
// Multi-stage synchroniser for one asynchronous pin, with registered
// rise/fall pulses aligned to the cycle in which the synchronised level
// changes.
module apbspi_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic nrst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              rise_q;
    logic              rise_d;
    logic              fall_q;
    logic              fall_d;

    // Next chain contents and edge detect on the value entering the last stage
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
        rise_d = sync_q[STAGES-2] & ~sync_q[STAGES-1];
        fall_d = ~sync_q[STAGES-2] & sync_q[STAGES-1];
    end

    // Synchroniser chain and edge pulse registers
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync_q <= {STAGES{RESET_VAL}};
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign q    = sync_q[STAGES-1];
    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/apbspi_spi_slave.sv
// SPI slave endpoint for the apbspi master: oversampled pins, modes 0-3,
// one-entry TX holding register and RX word buffer with valid/ready.
// Optional build macro APBSPI_SLAVE_LSB_FIRST_EN adds the lsb_first input.
module apbspi_spi_slave
    import apbspi_pkg::*;
#(
    parameter int WORD_WIDTH  = APBSPI_WORD_WIDTH,
    parameter int SYNC_STAGES = APBSPI_SYNC_STAGES
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  enable,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic                  sclk,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [WORD_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [WORD_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  overrun,
    output logic                  underrun,
    output logic                  frame_err,
    input  logic                  clr_flags
`ifdef APBSPI_SLAVE_LSB_FIRST_EN
    ,
    input  logic                  lsb_first
`endif
);

    localparam int              CNT_W    = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_WIDTH - 1);

    // Pin synchronisers: index 0 = sclk, 1 = cs_n (idles high), 2 = mosi
    logic [2:0] pin_raw;
    logic [2:0] pin_sync;
    logic [2:0] pin_rise;
    logic [2:0] pin_fall;

    assign pin_raw = {mosi, cs_n, sclk};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            apbspi_sync_edge #(
                .STAGES    (SYNC_STAGES),
                .RESET_VAL ((gi == 1) ? 1'b1 : 1'b0)
            ) u_sync (
                .clk  (clk),
                .nrst (nrst),
                .d    (pin_raw[gi]),
                .q    (pin_sync[gi]),
                .rise (pin_rise[gi]),
                .fall (pin_fall[gi])
            );
        end
    endgenerate

    logic unused_pins;
    assign unused_pins = ^{pin_sync[1:0], pin_rise[2], pin_fall[2]};

    logic mosi_s;
    logic cs_rise;
    logic cs_fall;
    logic lead_edge;
    logic trail_edge;
    logic sample_edge;
    logic shift_edge;

    assign mosi_s      = pin_sync[2];
    assign cs_rise     = pin_rise[1];
    assign cs_fall     = pin_fall[1];
    // Leading edge leaves the idle level, trailing edge returns to it
    assign lead_edge   = cpol ? pin_fall[0] : pin_rise[0];
    assign trail_edge  = cpol ? pin_rise[0] : pin_fall[0];
    assign sample_edge = cpha ? trail_edge : lead_edge;
    assign shift_edge  = cpha ? lead_edge  : trail_edge;

    apbspi_slave_state_t   state_q, state_d;
    logic [WORD_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [WORD_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [WORD_WIDTH-1:0] hold_q, hold_d;
    logic                  hold_full_q, hold_full_d;
    logic [WORD_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  miso_q, miso_d;
    logic                  miso_oe_q, miso_oe_d;
    logic                  overrun_q, overrun_d;
    logic                  underrun_q, underrun_d;
    logic                  frame_err_q, frame_err_d;

    logic                  hold_load;
    logic                  tx_write;
    logic                  word_done;
    logic                  underrun_set;
    logic                  overrun_set;
    logic                  frame_set;
    logic [WORD_WIDTH-1:0] load_word;
    logic [WORD_WIDTH-1:0] rx_word;
    logic                  lsb_mode;
    logic                  lsb_load;

`ifdef APBSPI_SLAVE_LSB_FIRST_EN
    logic lsb_q, lsb_d;
    assign lsb_mode = lsb_q;
    assign lsb_load = lsb_first;

    // Bit order latched at the start of each word
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            lsb_q <= 1'b0;
        end else begin
            lsb_q <= lsb_d;
        end
    end
`else
    assign lsb_mode = 1'b0;
    assign lsb_load = 1'b0;
`endif

    // Received word including the bit arriving on this sample edge
    assign rx_word = lsb_mode ? {mosi_s, rx_shift_q[WORD_WIDTH-1:1]}
                              : {rx_shift_q[WORD_WIDTH-2:0], mosi_s};

    // Frame sequencer: next state, shift registers and pin outputs
    always_comb begin
        state_d      = state_q;
        tx_shift_d   = tx_shift_q;
        rx_shift_d   = rx_shift_q;
        bit_cnt_d    = bit_cnt_q;
        miso_d       = miso_q;
        miso_oe_d    = miso_oe_q;
        hold_load    = 1'b0;
        underrun_set = 1'b0;
        frame_set    = 1'b0;
        word_done    = 1'b0;
        load_word    = hold_full_q ? hold_q : '0;
`ifdef APBSPI_SLAVE_LSB_FIRST_EN
        lsb_d        = lsb_q;
`endif
        if (!enable) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    bit_cnt_d = '0;
                    if (cs_fall) begin
                        state_d = LOAD;
                    end
                end
                LOAD: begin
                    // An empty holding register sends zeros and flags underrun
                    hold_load    = hold_full_q;
                    underrun_set = ~hold_full_q;
                    tx_shift_d   = load_word;
                    miso_d       = lsb_load ? load_word[0] : load_word[WORD_WIDTH-1];
                    miso_oe_d    = 1'b1;
                    bit_cnt_d    = '0;
`ifdef APBSPI_SLAVE_LSB_FIRST_EN
                    lsb_d        = lsb_first;
`endif
                    state_d      = cs_rise ? IDLE : SHIFT;
                end
                SHIFT: begin
                    if (cs_rise) begin
                        // Any coincident sclk edge is ignored; partial word dropped
                        state_d   = IDLE;
                        frame_set = (bit_cnt_q != '0);
                        bit_cnt_d = '0;
                    end else if (sample_edge) begin
                        rx_shift_d = rx_word;
                        if (bit_cnt_q == LAST_BIT) begin
                            word_done = 1'b1;
                            bit_cnt_d = '0;
                            state_d   = LOAD;
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end else if (shift_edge && (bit_cnt_q != '0)) begin
                        // With no bit sampled yet in this word the current miso
                        // bit came from LOAD, so this edge must not advance it
                        if (lsb_mode) begin
                            tx_shift_d = tx_shift_q >> 1;
                            miso_d     = tx_shift_q[1];
                        end else begin
                            tx_shift_d = tx_shift_q << 1;
                            miso_d     = tx_shift_q[WORD_WIDTH-2];
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        if (state_d == IDLE) begin
            miso_d    = 1'b0;
            miso_oe_d = 1'b0;
        end
    end

    // Word buffers, handshakes and sticky flags (set wins over clear)
    always_comb begin
        tx_write    = tx_valid && !hold_full_q;
        hold_d      = tx_write ? tx_data : hold_q;
        hold_full_d = hold_full_q;
        if (tx_write) begin
            hold_full_d = 1'b1;
        end else if (hold_load) begin
            hold_full_d = 1'b0;
        end

        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        overrun_set = 1'b0;
        if (word_done) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = rx_word;
                rx_valid_d = 1'b1;
            end else begin
                overrun_set = 1'b1;
            end
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        overrun_d   = overrun_set  | (overrun_q   & ~clr_flags);
        underrun_d  = underrun_set | (underrun_q  & ~clr_flags);
        frame_err_d = frame_set    | (frame_err_q & ~clr_flags);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= IDLE;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            bit_cnt_q   <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            miso_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
            overrun_q   <= 1'b0;
            underrun_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            bit_cnt_q   <= bit_cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            miso_q      <= miso_d;
            miso_oe_q   <= miso_oe_d;
            overrun_q   <= overrun_d;
            underrun_q  <= underrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign miso      = miso_q;
    assign miso_oe   = miso_oe_q;
    assign tx_ready  = ~hold_full_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign overrun   = overrun_q;
    assign underrun  = underrun_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_apbspi_spi_slave.sv
// Bench for apbspi_spi_slave: the bench acts as SPI master at clk/8 and
// compares received words and flags against expectations derived from the
// SPI exchange rules.
module tb_apbspi_spi_slave;

    localparam int HALF = 4;   // sclk half period in clk cycles

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        enable = 1'b1;
    logic        cpol = 1'b0;
    logic        cpha = 1'b0;
    logic        sclk = 1'b0;
    logic        cs_n = 1'b1;
    logic        mosi = 1'b0;
    logic        miso;
    logic        miso_oe;
    logic [31:0] tx_data = '0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        rx_ready = 1'b1;
    logic        overrun;
    logic        underrun;
    logic        frame_err;
    logic        clr_flags = 1'b0;
`ifdef APBSPI_SLAVE_LSB_FIRST_EN
    logic        lsb_first = 1'b0;
`endif

    always #5 clk = ~clk;

    apbspi_spi_slave dut (
        .clk       (clk),
        .nrst      (nrst),
        .enable    (enable),
        .cpol      (cpol),
        .cpha      (cpha),
        .sclk      (sclk),
        .cs_n      (cs_n),
        .mosi      (mosi),
        .miso      (miso),
        .miso_oe   (miso_oe),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .overrun   (overrun),
        .underrun  (underrun),
        .frame_err (frame_err),
`ifdef APBSPI_SLAVE_LSB_FIRST_EN
        .lsb_first (lsb_first),
`endif
        .clr_flags (clr_flags)
    );

    int          checks = 0;
    int          failures = 0;
    logic [31:0] m_tx [0:3];   // words the master shifts out on mosi
    logic [31:0] m_rx [0:3];   // words the master captured from miso
    logic [31:0] rx_got [$];   // words seen as new rx_valid events
    logic        rx_valid_prev = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Record each new word the slave presents
    always @(negedge clk) begin
        if (rx_valid && !rx_valid_prev) rx_got.push_back(rx_data);
        rx_valid_prev <= rx_valid;
    end

    // Master: nbits bits MSB-first across consecutive words under one CS
    task automatic spi_frame(input int nbits);
        @(negedge clk);
        cs_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int b = 0; b < nbits; b++) begin
            automatic int w = b / 32;
            automatic int i = 31 - (b % 32);
            if (!cpha) begin
                mosi = m_tx[w][i];
                repeat (HALF) @(negedge clk);
                sclk = ~cpol;
                m_rx[w][i] = miso;
                repeat (HALF) @(negedge clk);
                sclk = cpol;
            end else begin
                sclk = ~cpol;
                mosi = m_tx[w][i];
                repeat (HALF) @(negedge clk);
                sclk = cpol;
                m_rx[w][i] = miso;
                repeat (HALF) @(negedge clk);
            end
        end
        repeat (2 * HALF) @(negedge clk);
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    // Offer one word to the TX holding register, waiting for tx_ready
    task automatic push_tx(input logic [31:0] w);
        int n;
        n = 0;
        @(negedge clk);
        while (!tx_ready && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check("push_tx_ready", {31'b0, tx_ready}, 32'd1);
        tx_data  = w;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        @(negedge clk);
    endtask

    task automatic set_mode(input int mode);
        @(negedge clk);
        cpol = mode[1];
        cpha = mode[0];
        sclk = mode[1];
        repeat (8) @(negedge clk);
    endtask

    // Single-word exchange: slave returns txw, master sends mw. The second
    // LOAD at word end finds the holding register empty, so underrun sets.
    task automatic run_exchange(input string tag, input int mode,
                                input logic [31:0] txw, input logic [31:0] mw);
        set_mode(mode);
        push_tx(txw);
        rx_got.delete();
        m_tx[0] = mw;
        spi_frame(32);
        $display("XFER %s mode=%0d tx=0x%08h mosi=0x%08h miso_seen=0x%08h rx_words=%0d",
                 tag, mode, txw, mw, m_rx[0], rx_got.size());
        check({tag, "_rx_count"}, rx_got.size(), 32'd1);
        check({tag, "_rx_word"}, (rx_got.size() > 0) ? rx_got[0] : 32'hxxxx_xxxx, mw);
        check({tag, "_miso_word"}, m_rx[0], txw);
        check({tag, "_underrun"}, {31'b0, underrun}, 32'd1);
        check({tag, "_overrun"}, {31'b0, overrun}, 32'd0);
        check({tag, "_frame_err"}, {31'b0, frame_err}, 32'd0);
        check({tag, "_miso_oe_idle"}, {31'b0, miso_oe}, 32'd0);
        pulse_clr();
        check({tag, "_underrun_clr"}, {31'b0, underrun}, 32'd0);
    endtask

    logic [31:0] words [0:3];

    initial begin
        #100000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (4) @(negedge clk);
        check("rst_miso", {31'b0, miso}, 32'd0);
        check("rst_miso_oe", {31'b0, miso_oe}, 32'd0);
        check("rst_tx_ready", {31'b0, tx_ready}, 32'd1);
        check("rst_rx_valid", {31'b0, rx_valid}, 32'd0);
        check("rst_rx_data", rx_data, 32'd0);
        check("rst_flags", {29'b0, overrun, underrun, frame_err}, 32'd0);
        nrst = 1'b1;
        repeat (4) @(negedge clk);

        // Directed exchanges in every mode
        run_exchange("mode0", 0, 32'hA5A5_F00D, 32'h1234_5678);
        run_exchange("mode1", 1, 32'hDEAD_BEEF, 32'h0F0F_0F0F);
        run_exchange("mode2", 2, 32'hDEAD_BEEF, 32'h0F0F_0F0F);
        run_exchange("mode3", 3, 32'hDEAD_BEEF, 32'h0F0F_0F0F);

        // Randomised exchanges
        for (int k = 0; k < 4; k++) begin
            run_exchange("rand", int'($urandom_range(0, 3)), $urandom, $urandom);
        end

        // Back-to-back: three words under one CS, TX refilled on each tx_ready
        set_mode(0);
        for (int k = 0; k < 4; k++) words[k] = $urandom;
        for (int k = 0; k < 3; k++) m_tx[k] = $urandom;
        push_tx(words[0]);
        rx_got.delete();
        fork
            spi_frame(96);
            begin
                for (int k = 1; k < 4; k++) push_tx(words[k]);
            end
        join
        $display("XFER b2b words=3 rx_words=%0d", rx_got.size());
        check("b2b_rx_count", rx_got.size(), 32'd3);
        for (int k = 0; k < 3; k++) begin
            check("b2b_rx_word", (rx_got.size() > k) ? rx_got[k] : 32'hxxxx_xxxx, m_tx[k]);
            check("b2b_miso_word", m_rx[k], words[k]);
        end
        check("b2b_flags", {29'b0, overrun, underrun, frame_err}, 32'd0);

        // Overrun/underrun: two words, rx_ready low, single TX word
        set_mode(1);
        @(negedge clk);
        rx_ready = 1'b0;
        words[0] = $urandom;
        m_tx[0] = $urandom;
        m_tx[1] = $urandom;
        push_tx(words[0]);
        rx_got.delete();
        spi_frame(64);
        $display("XFER overrun words=2 rx_data=0x%08h", rx_data);
        check("ovr_rx_data_kept", rx_data, m_tx[0]);
        check("ovr_rx_valid", {31'b0, rx_valid}, 32'd1);
        check("ovr_overrun", {31'b0, overrun}, 32'd1);
        check("ovr_underrun", {31'b0, underrun}, 32'd1);
        check("ovr_miso_word0", m_rx[0], words[0]);
        check("ovr_miso_word1", m_rx[1], 32'h0000_0000);
        pulse_clr();
        check("ovr_flags_clr", {29'b0, overrun, underrun, frame_err}, 32'd0);
        check("ovr_rx_valid_held", {31'b0, rx_valid}, 32'd1);
        rx_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("ovr_rx_drained", {31'b0, rx_valid}, 32'd0);
        check("ovr_rx_count", rx_got.size(), 32'd1);

        // Frame error: CS released after 13 bits
        set_mode(0);
        push_tx($urandom);
        rx_got.delete();
        m_tx[0] = $urandom;
        spi_frame(13);
        $display("XFER partial bits=13 frame_err=%0d", frame_err);
        check("ferr_flag", {31'b0, frame_err}, 32'd1);
        check("ferr_no_rx", rx_got.size(), 32'd0);
        check("ferr_rx_valid", {31'b0, rx_valid}, 32'd0);
        check("ferr_miso_oe", {31'b0, miso_oe}, 32'd0);
        check("ferr_underrun", {31'b0, underrun}, 32'd0);
        pulse_clr();
        check("ferr_clr", {31'b0, frame_err}, 32'd0);
        run_exchange("after_ferr", 0, $urandom, $urandom);

        // Reset asserted at bit 20 of a frame
        set_mode(0);
        push_tx($urandom);
        m_tx[0] = $urandom;
        fork
            spi_frame(32);
            begin
                repeat (8 + 20 * 2 * HALF + 2) @(negedge clk);
                nrst = 1'b0;
                #1;
                $display("XFER reset_mid_frame");
                check("midrst_miso", {31'b0, miso}, 32'd0);
                check("midrst_miso_oe", {31'b0, miso_oe}, 32'd0);
                check("midrst_tx_ready", {31'b0, tx_ready}, 32'd1);
                check("midrst_rx_valid", {31'b0, rx_valid}, 32'd0);
                check("midrst_rx_data", rx_data, 32'd0);
                check("midrst_flags", {29'b0, overrun, underrun, frame_err}, 32'd0);
            end
        join
        repeat (4) @(negedge clk);
        nrst = 1'b1;
        repeat (4) @(negedge clk);
        run_exchange("after_rst", 0, $urandom, $urandom);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
